// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and parity helper, used by the transmit and
// receive paths.
package uart_tx_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  // Tick counters are never narrower than this, even for fast baud rates.
  localparam int unsigned MinTickWidth = 14;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses for one cycle every TICKS_PER_BIT cycles, and the
// count restarts from zero whenever clear is asserted.
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned TICKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CntW =
      ($clog2(TICKS_PER_BIT) > MinTickWidth) ? $clog2(TICKS_PER_BIT) : MinTickWidth;
  localparam logic [CntW-1:0] LastTick = CntW'(TICKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LastTick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign bit_tick = (cnt_q == LastTick);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for 8E1 framing.
// One byte is accepted per frame via a valid/ready handshake; tx is fully registered.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned SYS_CLK_SPEED = 100_000_000,
  parameter int unsigned TICKS_PER_BIT = SYS_CLK_SPEED / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       tx_q, tx_d;
  logic       accept;
  logic       bit_tick;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign tx_ready = (state_q == StIdle) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state_q != StIdle);
  assign tx       = tx_q;

  uart_baud_gen #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .bit_tick(bit_tick)
  );

  // tx_d is the line level for the state being entered, so tx changes on the state edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = StStart;
          shift_d   = tx_data;
          bit_cnt_d = 4'd0;
          tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(tx_data);
`endif
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_cnt_q == 4'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_tick) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_tick) begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; frame width follows UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int unsigned SysClk = 1_000_000;
  localparam int unsigned Baud   = 100_000;
  localparam int          T      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          NB     = 11;
`else
  localparam int          NB     = 10;
`endif
  localparam int          FL     = NB * T;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;

  logic wave  [1:256];
  logic busyw [1:256];

  uart_tx #(
    .BAUD_RATE    (Baud),
    .SYS_CLK_SPEED(SysClk),
    .TICKS_PER_BIT(T)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot b of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Presents d and returns 1 time unit after the accepting edge (frame cycle 1).
  task automatic accept(input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: tx_ready=%b required 1 within 300 cycles", tx_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Samples n cycles; at cycle 'at' drives tx_data=pd and, if pv, a one-cycle tx_valid pulse.
  task automatic capture(input int n, input int at, input logic [7:0] pd, input bit pv);
    for (int k = 1; k <= n; k++) begin
      wave[k]  = tx;
      busyw[k] = tx_busy;
      if (k == at) begin
        tx_data = pd;
        if (pv) tx_valid = 1'b1;
      end
      if (k == at + 1 && pv) tx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1) begin
      bad++;
      $display("FAIL reset_tx: got %b required 1", tx);
    end
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %b required 0", tx_ready);
    end
    total++;
    if (tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b required 0", tx_busy);
    end
    tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b required 1", tx_ready);
    end
  endtask

  task automatic test_single();
    logic e;
    int   errs;
    accept(8'hA5, 1'b0);
    capture(FL, 0, 8'h00, 1'b0);
    for (int b = 0; b < NB; b++) begin
      e    = exp_bit(8'hA5, b);
      errs = 0;
      for (int c = 0; c < T; c++) if (wave[1 + b*T + c] !== e) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL single_A5 slot%0d: %0d samples differ from required %b", b, errs, e);
      end
    end
    total++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end: ready=%b busy=%b required 1 0", tx_ready, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int   errs;
    accept(8'h00, 1'b1);
    tx_data = 8'hFF;
    capture(FL, 0, 8'hFF, 1'b0);
    for (int b = 0; b < NB; b++) begin
      e    = exp_bit(8'h00, b);
      errs = 0;
      for (int c = 0; c < T; c++) if (wave[1 + b*T + c] !== e) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL b2b_00 slot%0d: %0d samples differ from required %b", b, errs, e);
      end
    end
    // Single idle cycle between frames.
    total++;
    if (tx !== 1'b1 || tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: tx=%b ready=%b required 1 1", tx, tx_ready);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    total++;
    if (tx !== 1'b0 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_start: tx=%b ready=%b required 0 0", tx, tx_ready);
    end
    capture(FL, 0, 8'h00, 1'b0);
    for (int b = 0; b < NB; b++) begin
      e    = exp_bit(8'hFF, b);
      errs = 0;
      for (int c = 0; c < T; c++) if (wave[1 + b*T + c] !== e) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL b2b_FF slot%0d: %0d samples differ from required %b", b, errs, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic e;
    int   errs;
    accept(8'h55, 1'b0);
    capture(FL, 30, 8'h3C, 1'b1);
    for (int b = 0; b < NB; b++) begin
      e    = exp_bit(8'h55, b);
      errs = 0;
      for (int c = 0; c < T; c++) if (wave[1 + b*T + c] !== e) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL ignore_55 slot%0d: %0d samples differ from required %b", b, errs, e);
      end
    end
    capture(40, 0, 8'h3C, 1'b0);
    errs = 0;
    for (int k = 1; k <= 40; k++) if (wave[k] !== 1'b1 || busyw[k] !== 1'b0) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL ignore_no_3C: %0d idle samples not tx=1 busy=0", errs);
    end
  endtask

  task automatic test_mid_reset();
    int errs;
    accept(8'h81, 1'b0);
    capture(34, 0, 8'h81, 1'b0);
    // Cycle 35 lies in data bit 2 of 0x81, which is 0.
    total++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_before: tx=%b busy=%b required 0 1", tx, tx_busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_abort: tx=%b busy=%b ready=%b required 1 0 0", tx, tx_busy,
               tx_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready: got %b required 1", tx_ready);
    end
    capture(30, 0, 8'h81, 1'b0);
    errs = 0;
    for (int k = 1; k <= 30; k++) if (wave[k] !== 1'b1 || busyw[k] !== 1'b0) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL midrst_no_resume: %0d samples not tx=1 busy=0", errs);
    end
  endtask

  task automatic test_data_hold();
    logic e;
    int   errs;
    accept(8'h12, 1'b0);
    capture(FL, 1, 8'hED, 1'b0);
    for (int b = 0; b < NB; b++) begin
      e    = exp_bit(8'h12, b);
      errs = 0;
      for (int c = 0; c < T; c++) if (wave[1 + b*T + c] !== e) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL hold_12 slot%0d: %0d samples differ from required %b", b, errs, e);
      end
    end
  endtask

  task automatic test_frame_len();
    int busy_cnt;
    logic e;
    int   errs;
    accept(8'h07, 1'b0);
    capture(FL + 5, 0, 8'h07, 1'b0);
    busy_cnt = 0;
    for (int k = 1; k <= FL + 5; k++) if (busyw[k] === 1'b1) busy_cnt++;
    total++;
    if (busy_cnt != FL) begin
      bad++;
      $display("FAIL frame_len: got %0d cycles required %0d", busy_cnt, FL);
    end
    // Slot 9 is the parity bit (1 for 0x07) in 8E1, the stop bit in 8N1.
    e    = exp_bit(8'h07, 9);
    errs = 0;
    for (int c = 0; c < T; c++) if (wave[1 + 9*T + c] !== e) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL frame_07_slot9: %0d samples differ from required %b", errs, e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
    test_data_hold();
    test_frame_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
